imm_ext_stage: RTL and testbench
================================

# imm_ext_stage

Parametrised immediate-extension pipeline stage between decode and execute. Takes the upper instruction bits, an extended immediate-format select and a pass-through tag, and produces the sign- or zero-extended immediate one cycle later. Output is registered behind a two-entry skid buffer with valid/ready handshaking, so execute-side stalls never create a combinational path back to decode. Supports every RV32I/RV64I immediate format, including U-type, CSR zimm and shift amounts, and flags reserved selects.

## Interface
- `XLEN`, 32: immediate width; legal values are 32 and 64.
- `TAG_W`, 8: width of the opaque tag carried alongside each immediate (rd/ROB id).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream holds a valid request.
- `in_ready` output 1: stage can accept a request this cycle.
- `instr` input 25 (`[31:7]`): instruction bits 31..7.
- `imm_src` input 3: format select (see Operation).
- `in_tag` input TAG_W: tag travelling with the request.
- `flush` input 1: synchronous kill of all held entries.
- `out_valid` output 1: `out_imm`/`out_tag`/`out_err` are valid.
- `out_ready` input 1: downstream accepts the output this cycle.
- `out_imm` output XLEN: extended immediate.
- `out_tag` output TAG_W: tag of the output entry.
- `out_err` output 1: the entry was produced from a reserved `imm_src`.

## Operation
- Format decode, with `s` = `instr[31]` replicated up to XLEN:
  - 000 I: `{s, instr[31:20]}`
  - 001 S: `{s, instr[31:25], instr[11:7]}`
  - 010 B: `{s, instr[7], instr[30:25], instr[11:8], 0}`
  - 011 J: `{s, instr[19:12], instr[20], instr[30:21], 0}`
  - 100 U: `{s, instr[31:12], 12'b0}`; for XLEN=64, bits 63:32 are sign-extended from bit 31.
  - 101 Z: zero-extended `instr[19:15]`
  - 110 SHAMT: zero-extended `instr[24:20]` (XLEN=32) or `instr[25:20]` (XLEN=64)
  - 111: imm = 0, err = 1. Err = 0 for all other selects.
- Accept: `in_valid && in_ready`.
- Deliver: `out_valid && out_ready`.
- Storage: output register (OUT) and skid register (SKID). States are EMPTY, ONE (OUT full) and TWO (OUT and SKID full).
- EMPTY:
  - Accept loads OUT and moves to ONE.
- ONE:
  - Accept with no deliver loads SKID and moves to TWO.
  - Accept with deliver reloads OUT and stays in ONE.
  - Deliver alone moves to EMPTY.
- TWO:
  - Deliver moves SKID into OUT and goes to ONE. No accept is possible in TWO.
- `in_ready = (state != TWO) && !flush`. It depends only on state and `flush`, never on `out_ready`.
- `flush`: next state is EMPTY and no accept occurs. `out_valid` drops the following cycle. A deliver in the same cycle still counts as delivered.
- `out_*` always reflect OUT. When `out_valid` = 0, OUT contents are don't-care, except after reset (see below).
- With `out_valid` high and `out_ready` low, the `out_*` values must not change.

## Timing
- Reset values:
  - State EMPTY.
  - `out_valid` 0, `in_ready` 1.
  - `out_imm` 0, `out_tag` 0, `out_err` 0.
  - SKID cleared.
- Reset asserted mid-transfer discards both entries immediately, without waiting for a clock edge.
- Latency: accept in cycle N gives `out_valid` in cycle N+1.
- Throughput: one request per cycle while `out_ready` stays high.
- Back-pressure: after `out_ready` falls, at most one further request is absorbed (into SKID), then `in_ready` falls.
- Ordering is strict FIFO. No entry is lost or duplicated across stall/flush boundaries.

## Structure
- Shared package `imm_pkg`:
  - enum `imm_src_t` with values IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SHAMT, IMM_RSVD.
  - `XLEN` legality check.
- Combinational sub-module `imm_decode` (params XLEN; ports instr, imm_src, imm, err). It is instantiated once, on the input side.
- The skid/state logic lives in `imm_ext_stage`.

## Test plan
- After reset, with `out_ready` = 1 and XLEN=32:
  - I `0xFFF00093` → next cycle `out_imm` 0xFFFFFFFF.
  - B `0xFE000EE3` → 0xFFFFFFFC.
  - J `0x0080006F` → 0x00000008.
  - U `0x123450B7` → 0x12345000.
- XLEN=64:
  - U `0x800000B7` → 0xFFFFFFFF80000000.
  - SHAMT with `instr[25:20]` = 63 → 0x3F.
  - Z with `instr[19:15]` = 31 → 0x1F.
- Back-pressure: hold `out_ready` = 0 while streaming tags 1, 2, 3.
  - Tags 1 and 2 are accepted and `in_ready` falls.
  - On releasing `out_ready`, tags 1, 2, 3 emerge in order with values unchanged while stalled.
- Flush in state TWO: next cycle `out_valid` = 0 and `in_ready` = 1. A tag offered during the flush cycle never appears.
- `imm_src` = 111 → `out_imm` 0, `out_err` 1.
- Assert `reset` asynchronously between edges while in TWO:
  - Outputs go to their reset values immediately.
  - After release, `in_ready` = 1 and no stale tag is emitted.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and checks for the immediate-extension stage.
package imm_pkg;

    // Immediate format select, encoded as carried on the imm_src bus.
    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_Z     = 3'b101,
        IMM_SHAMT = 3'b110,
        IMM_RSVD  = 3'b111
    } imm_src_t;

    // Only RV32 and RV64 register widths are meaningful for this stage.
    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_ext_stage_if.sv
// Request/response bundle between decode, the immediate stage and execute.
interface imm_ext_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) ();
    import imm_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:7]      instr;
    imm_src_t         imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    // Environment side: drives requests and the downstream ready.
    modport master (
        output in_valid, instr, imm_src, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    // Stage side.
    modport slave (
        input  in_valid, instr, imm_src, in_tag, flush, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate extraction and extension.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_src_t        imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Signed formats are built at their natural width and sign-extended by the cast.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_src)
            IMM_I: imm = XLEN'($signed(instr[31:20]));
            IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            IMM_Z: imm = XLEN'(instr[19:15]);
            IMM_SHAMT: begin
                if (XLEN == 64) imm = XLEN'(instr[25:20]);
                else            imm = XLEN'(instr[24:20]);
            end
            IMM_RSVD: err = 1'b1;
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Immediate-extension pipeline stage: decode on the input side, then a
// two-entry skid buffer so out_ready never reaches in_ready combinationally.
module imm_ext_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input logic            clk,
    input logic            reset,
    imm_ext_stage_if.slave bus
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_ext_stage: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
    logic             out_err_q, out_err_d, skid_err_q, skid_err_d;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;
    logic             ready;
    logic             accept;
    logic             deliver;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (bus.instr),
        .imm_src (bus.imm_src),
        .imm     (dec_imm),
        .err     (dec_err)
    );

    // ready depends only on occupancy and flush, keeping execute stalls off the decode path.
    assign ready   = (state_q != StTwo) && !bus.flush;
    assign accept  = bus.in_valid && ready;
    assign deliver = (state_q != StEmpty) && bus.out_ready;

    // Next-state and entry movement between input, OUT and SKID.
    always_comb begin
        state_d    = state_q;
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        out_err_d  = out_err_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_err_d = skid_err_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    out_imm_d = dec_imm;
                    out_tag_d = bus.in_tag;
                    out_err_d = dec_err;
                    state_d   = StOne;
                end
            end
            StOne: begin
                if (accept && !deliver) begin
                    skid_imm_d = dec_imm;
                    skid_tag_d = bus.in_tag;
                    skid_err_d = dec_err;
                    state_d    = StTwo;
                end else if (accept) begin
                    out_imm_d = dec_imm;
                    out_tag_d = bus.in_tag;
                    out_err_d = dec_err;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (deliver) begin
                    out_imm_d = skid_imm_q;
                    out_tag_d = skid_tag_q;
                    out_err_d = skid_err_q;
                    state_d   = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins: held contents become don't-care once empty.
        if (bus.flush) state_d = StEmpty;
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StEmpty;
        else       state_q <= state_d;
    end

    // OUT and SKID data registers, cleared so outputs read zero straight after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_err_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            out_err_q  <= out_err_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_err_q <= skid_err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q != StEmpty);
    assign bus.out_imm   = out_imm_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked against an arithmetic FIFO reference model.
module tb_imm_ext_stage;
    import imm_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [31:7] instr_v = '0;
    imm_src_t   src_v = IMM_I;
    logic [7:0] tag_v = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [7:0]  tag;
        logic        err;
    } entry_t;

    entry_t     q[$];
    logic [7:0] dtags[$];

    always #5 clk = ~clk;

    imm_ext_stage_if #(.XLEN(32), .TAG_W(8)) if32 ();
    imm_ext_stage_if #(.XLEN(64), .TAG_W(8)) if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.instr     = instr_v;
    assign if32.imm_src   = src_v;
    assign if32.in_tag    = tag_v;
    assign if32.flush     = flush;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.instr     = instr_v;
    assign if64.imm_src   = src_v;
    assign if64.in_tag    = tag_v;
    assign if64.flush     = flush;
    assign if64.out_ready = out_ready;

    imm_ext_stage #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
    imm_ext_stage #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint fld(logic [31:0] w, int hi, int lo);
        logic [31:0] m;
        m = (32'd1 << (hi - lo + 1)) - 32'd1;
        return longint'((w >> lo) & m);
    endfunction

    // Immediate value as a signed integer from the bit weights of each format.
    function automatic logic [63:0] ref_imm(logic [31:0] w, logic [2:0] src, bit x64);
        longint v;
        longint sg;
        sg = w[31] ? 64'sd1 : 64'sd0;
        case (src)
            3'd0: v = fld(w, 31, 20) - sg * 4096;
            3'd1: v = fld(w, 31, 25) * 32 + fld(w, 11, 7) - sg * 4096;
            3'd2: v = fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2 - sg * 4096;
            3'd3: v = fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2
                      - sg * (longint'(1) << 20);
            3'd4: v = fld(w, 31, 12) * 4096 - sg * (longint'(1) << 32);
            3'd5: v = fld(w, 19, 15);
            3'd6: v = x64 ? fld(w, 25, 20) : fld(w, 24, 20);
            default: v = 0;
        endcase
        return v;
    endfunction

    // One cycle: drive inputs after a falling edge, check against the model, advance.
    task automatic step(bit iv, logic [31:0] w, logic [2:0] src, logic [7:0] tg, bit ordy,
                        bit fl);
        bit     mvalid, mready;
        entry_t e;
        in_valid  = iv;
        instr_v   = w[31:7];
        src_v     = imm_src_t'(src);
        tag_v     = tg;
        out_ready = ordy;
        flush     = fl;
        #1;
        mvalid = (q.size() > 0);
        mready = (q.size() < 2) && !fl;
        check_eq("out_valid32", 64'(if32.out_valid), 64'(mvalid));
        check_eq("out_valid64", 64'(if64.out_valid), 64'(mvalid));
        check_eq("in_ready32", 64'(if32.in_ready), 64'(mready));
        check_eq("in_ready64", 64'(if64.in_ready), 64'(mready));
        if (mvalid) begin
            check_eq("imm32", 64'(if32.out_imm), {32'd0, q[0].imm32[31:0]});
            check_eq("imm64", if64.out_imm, q[0].imm64);
            check_eq("tag32", 64'(if32.out_tag), 64'(q[0].tag));
            check_eq("tag64", 64'(if64.out_tag), 64'(q[0].tag));
            check_eq("err32", 64'(if32.out_err), 64'(q[0].err));
            check_eq("err64", 64'(if64.out_err), 64'(q[0].err));
        end
        if (mvalid && ordy) begin
            dtags.push_back(q[0].tag);
            void'(q.pop_front());
        end
        if (iv && mready) begin
            e.imm32 = ref_imm(w, src, 1'b0);
            e.imm64 = ref_imm(w, src, 1'b1);
            e.tag   = tg;
            e.err   = (src == 3'd7);
            q.push_back(e);
        end
        if (fl) q.delete();
        @(negedge clk);
    endtask

    task automatic directed(string name, logic [31:0] w, logic [2:0] src, logic [63:0] e32,
                            logic [63:0] e64, logic eerr);
        step(1'b1, w, src, 8'h5A, 1'b1, 1'b0);
        check_eq({name, "_32"}, 64'(if32.out_imm), e32);
        check_eq({name, "_64"}, if64.out_imm, e64);
        check_eq({name, "_err"}, 64'(if64.out_err), 64'(eerr));
    endtask

    task automatic check_reset_values(string name);
        check_eq({name, "_valid"}, 64'({if32.out_valid, if64.out_valid}), 64'd0);
        check_eq({name, "_ready"}, 64'({if32.in_ready, if64.in_ready}), 64'd3);
        check_eq({name, "_imm32"}, 64'(if32.out_imm), 64'd0);
        check_eq({name, "_imm64"}, if64.out_imm, 64'd0);
        check_eq({name, "_tag"}, 64'({if32.out_tag, if64.out_tag}), 64'd0);
        check_eq({name, "_err"}, 64'({if32.out_err, if64.out_err}), 64'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        directed("i_type", 32'hFFF00093, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        directed("b_type", 32'hFE000EE3, 3'd2, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        directed("j_type", 32'h0080006F, 3'd3, 64'h8, 64'h8, 1'b0);
        directed("u_pos", 32'h123450B7, 3'd4, 64'h12345000, 64'h12345000, 1'b0);
        directed("u_neg", 32'h800000B7, 3'd4, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        directed("shamt", 32'h03F00000, 3'd6, 64'h1F, 64'h3F, 1'b0);
        directed("zimm", 32'h000F8000, 3'd5, 64'h1F, 64'h1F, 1'b0);
        directed("rsvd", 32'hFFFFFFFF, 3'd7, 64'h0, 64'h0, 1'b1);
        step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);
        step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);

        // Back-pressure: only tags 1 and 2 fit while stalled; 3 waits.
        dtags.delete();
        step(1'b1, 32'h00100000, 3'd0, 8'd1, 1'b0, 1'b0);
        step(1'b1, 32'h00200000, 3'd0, 8'd2, 1'b0, 1'b0);
        step(1'b1, 32'h00300000, 3'd0, 8'd3, 1'b0, 1'b0);
        step(1'b1, 32'h00300000, 3'd0, 8'd3, 1'b0, 1'b0);
        step(1'b1, 32'h00300000, 3'd0, 8'd3, 1'b1, 1'b0);
        step(1'b1, 32'h00300000, 3'd0, 8'd3, 1'b1, 1'b0);
        step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);
        step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);
        check_eq("bp_count", 64'(dtags.size()), 64'd3);
        for (int i = 0; i < 3 && i < dtags.size(); i++) check_eq("bp_order", 64'(dtags[i]), 64'(i + 1));

        // Flush while two entries are held; the tag offered during flush must vanish.
        step(1'b1, 32'h00500000, 3'd0, 8'd4, 1'b0, 1'b0);
        step(1'b1, 32'h00600000, 3'd0, 8'd5, 1'b0, 1'b0);
        step(1'b1, 32'h00700000, 3'd0, 8'hAA, 1'b0, 1'b1);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check_eq("flush_valid", 64'({if32.out_valid, if64.out_valid}), 64'd0);
        check_eq("flush_ready", 64'({if32.in_ready, if64.in_ready}), 64'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while full.
        step(1'b1, 32'h00800000, 3'd1, 8'd6, 1'b0, 1'b0);
        step(1'b1, 32'h00900000, 3'd2, 8'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        #2 reset = 1'b0;
        q.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 8'($urandom), ($urandom_range(0, 1) != 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 3'd0, 8'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
